mcp_chan_mux: RTL
=================

// Module: mcp_chan_mux
// PURPOSE
//  Multi-channel multi-cycle-path transfer source, single clock domain.
//  - CHANNELS independent producers each post a SIZE-bit word with a 1-cycle rdy pulse.
//  - Each word is held in a per-channel holding register.
//  - Pending words are served round-robin over a 4-phase rdy/ack level handshake.
//  - The handshake drives one downstream MCP synchroniser, so many status/control words share one crossing.
// PARAMETERS
//  SIZE      16  data width per channel, >=1
//  CHANNELS  4   number of producer channels, 2..16
//  CW        $clog2(CHANNELS)  derived (localparam), channel index width
// PORTS
//  clk        in   1              system clock
//  rst_n      in   1              synchronous reset, active low
//  ch_data    in   SIZE*CHANNELS  channel i word at [i*SIZE +: SIZE]
//  ch_rdy     in   CHANNELS       1-cycle pulse per channel: capture ch_data slice
//  ch_pend    out  CHANNELS       word held, not yet granted
//  ch_ovf     out  CHANNELS       1-cycle pulse: pending word overwritten (dropped)
//  out_data   out  SIZE           granted word, stable while out_rdy=1
//  out_ch     out  CW             source channel of out_data
//  out_rdy    out  1              level: word offered downstream
//  out_ack    in   1              level: downstream ack (already synchronised into clk)
//  drop_cnt   out  16             saturating count of dropped words (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): all outputs 0, hold regs 0, state IDLE, rr pointer 0.
//  Capture: ch_rdy[i]=1 at edge -> hold[i]<=slice i, ch_pend[i]<=1 at that edge.
//  Overflow: ch_rdy[i] while ch_pend[i]=1 and channel i not granted this cycle.
//   - Latest wins: hold[i] overwritten.
//   - ch_ovf[i]=1 for one cycle.
//   - drop_cnt+1.
//  Grant same cycle as ch_rdy[i] on the same channel:
//   - out_data takes the old hold[i].
//   - hold[i] takes the new word; ch_pend[i] stays 1.
//   - Not an overflow.
//  FSM:
//   - IDLE: if any ch_pend -> pick first pending at or after rr pointer (wrapping).
//     Load out_data/out_ch, clear ch_pend of winner, out_rdy<=1, rr<=winner+1 mod CHANNELS.
//     Go REQ.
//   - REQ: hold out_rdy=1, out_data, out_ch. On out_ack=1: out_rdy<=0, go REL.
//   - REL: wait out_ack=0, then go IDLE.
//  IDLE grant uses ch_pend registered state: idle ch_rdy at edge N -> out_rdy=1 after edge N+1.
//  Throughput: one word per 4-phase cycle; next out_rdy no earlier than 1 cycle after out_ack falls.
//  out_ack=1 in IDLE (stale): ignored; grant waits until out_ack=0.
//  Reset mid-handshake: FSM to IDLE, out_rdy=0, all pending words discarded, no ch_ovf.
// CONFIGURATION
//  MCP_DROP_CNT_EN defined:
//   - drop_cnt is a 16-bit counter: +1 per overflowed channel per cycle (popcount of ch_ovf).
//   - Saturates at 16'hFFFF; cleared only by reset.
//  MCP_DROP_CNT_EN undefined: drop_cnt tied 16'h0000, no counter logic; ch_ovf unaffected.
// TESTING
//  1 Reset: rst_n=0 3 clks with random ch_rdy -> all outputs 0, out_rdy never 1.
//  2 Single: ch_rdy=4'b0010, data1=16'hA5A5; ack 3 clks after out_rdy
//     -> out_rdy 2 edges after pulse, out_ch=1, out_data=A5A5 until ack, then REL/IDLE.
//  3 Round robin: ch_rdy=4'b1111 once, data=i+1, ack 2-cycle delay
//     -> grant order 0,1,2,3, rr wraps, ch_pend drains to 0.
//  4 Overflow: ch2 pulsed 16'h1111 then 16'h2222 while REQ busy on ch0
//     -> ch_ovf[2] 1 clk, drop_cnt=1 (EN) / 0 (no EN), ch2 later sends 2222.
//  5 Same-cycle: ch1 pulse 16'h3333 on its grant edge
//     -> old word out, 3333 pending, ch_ovf=0.
//  6 Stale ack/reset mid-REQ: out_ack held 1 entering IDLE -> no grant until 0;
//     rst_n=0 during REQ -> out_rdy 0 next edge, ch_pend 0.

Source files
------------

// File: rtl/mcp_chan_mux.sv
// mcp_chan_mux: multi-channel source for a single multi-cycle-path (MCP) crossing.
// Each producer posts a word with a 1-cycle ch_rdy pulse into its own holding register.
// Pending words are granted round-robin and offered downstream over a 4-phase
// out_rdy/out_ack level handshake, so many status/control words share one synchroniser.
// Optional feature: define MCP_DROP_CNT_EN to build the saturating dropped-word counter;
// without it drop_cnt is tied to zero and ch_ovf still reports every overwrite.
module mcp_chan_mux #(
   parameter int unsigned SIZE     = 16,
   parameter int unsigned CHANNELS = 4,
   localparam int unsigned CW      = $clog2(CHANNELS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [SIZE*CHANNELS-1:0] ch_data,
   input  logic [CHANNELS-1:0]      ch_rdy,
   output logic [CHANNELS-1:0]      ch_pend,
   output logic [CHANNELS-1:0]      ch_ovf,
   output logic [SIZE-1:0]          out_data,
   output logic [CW-1:0]            out_ch,
   output logic                     out_rdy,
   input  logic                     out_ack,
   output logic [15:0]              drop_cnt
);

   typedef enum logic [1:0] {StIdle, StReq, StRel} state_e;

   state_e              state_q, state_d;
   logic [SIZE-1:0]     hold_q [CHANNELS];
   logic [SIZE-1:0]     hold_d [CHANNELS];
   logic [CHANNELS-1:0] pend_q, pend_d;
   logic [CHANNELS-1:0] ovf_q, ovf_d;
   logic [CHANNELS-1:0] grant_vec;
   logic [CW-1:0]       rr_q, rr_d;
   logic [CW-1:0]       win;
   logic                win_found;
   logic                grant;
   logic [CW:0]         rr_sum;
   logic [SIZE-1:0]     out_data_q, out_data_d;
   logic [CW-1:0]       out_ch_q, out_ch_d;
   logic                out_rdy_q, out_rdy_d;

   // Round-robin search: first pending channel at or after rr_q, wrapping.
   always_comb begin
      win_found = 1'b0;
      win       = '0;
      rr_sum    = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         rr_sum = {1'b0, rr_q} + (CW+1)'(k);
         if (rr_sum >= (CW+1)'(CHANNELS)) begin
            rr_sum = rr_sum - (CW+1)'(CHANNELS);
         end
         if (!win_found && pend_q[rr_sum[CW-1:0]]) begin
            win_found = 1'b1;
            win       = rr_sum[CW-1:0];
         end
      end
   end

   // Grant only from IDLE with the downstream ack released; a stale ack blocks the grant.
   always_comb begin
      grant     = (state_q == StIdle) && win_found && !out_ack;
      grant_vec = '0;
      if (grant) begin
         grant_vec[win] = 1'b1;
      end
      rr_d = rr_q;
      if (grant) begin
         rr_d = (win == CW'(CHANNELS - 1)) ? '0 : win + CW'(1);
      end
   end

   // Per-channel capture, pending and overflow; a pulse on the granted channel re-arms it.
   always_comb begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         hold_d[i] = hold_q[i];
         if (ch_rdy[i]) begin
            hold_d[i] = ch_data[i*SIZE +: SIZE];
         end
      end
      pend_d = (pend_q & ~grant_vec) | ch_rdy;
      ovf_d  = ch_rdy & pend_q & ~grant_vec;
   end

   // Handshake FSM next-state and output registers.
   always_comb begin
      state_d    = state_q;
      out_rdy_d  = out_rdy_q;
      out_data_d = out_data_q;
      out_ch_d   = out_ch_q;
      unique case (state_q)
         StIdle: begin
            if (grant) begin
               // hold_q is the pre-capture word, so a same-cycle pulse is not lost.
               out_data_d = hold_q[win];
               out_ch_d   = win;
               out_rdy_d  = 1'b1;
               state_d    = StReq;
            end
         end
         StReq: begin
            if (out_ack) begin
               out_rdy_d = 1'b0;
               state_d   = StRel;
            end
         end
         StRel: begin
            if (!out_ack) begin
               state_d = StIdle;
            end
         end
         default: begin
            out_rdy_d = 1'b0;
            state_d   = StIdle;
         end
      endcase
   end

   // State, holding registers and handshake outputs; reset discards pending words.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         pend_q     <= '0;
         ovf_q      <= '0;
         rr_q       <= '0;
         out_data_q <= '0;
         out_ch_q   <= '0;
         out_rdy_q  <= 1'b0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            hold_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         ovf_q      <= ovf_d;
         rr_q       <= rr_d;
         out_data_q <= out_data_d;
         out_ch_q   <= out_ch_d;
         out_rdy_q  <= out_rdy_d;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            hold_q[i] <= hold_d[i];
         end
      end
   end

`ifdef MCP_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [4:0]  ovf_num;
   logic [16:0] drop_sum;

   // Saturating add of the number of channels overflowing this cycle.
   always_comb begin
      ovf_num = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         ovf_num = ovf_num + 5'(ovf_d[i]);
      end
      drop_sum   = {1'b0, drop_cnt_q} + 17'(ovf_num);
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   // Drop counter register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 16'h0000;
`endif

   assign ch_pend  = pend_q;
   assign ch_ovf   = ovf_q;
   assign out_data = out_data_q;
   assign out_ch   = out_ch_q;
   assign out_rdy  = out_rdy_q;

endmodule
